// File: rtl/debug_access_ctrl_pkg.sv
// Shared widths, debug-mode encodings and command opcodes for the debug access sequencer.
// Imported by debug_access_ctrl and by anything that builds or decodes its commands.
package debug_access_ctrl_pkg;

  localparam int unsigned DATA_WIDTH  = 32;
  localparam int unsigned IADDR_WIDTH = 10;
  localparam int unsigned RADDR_WIDTH = 5;
  localparam int unsigned DADDR_WIDTH = 10;
  localparam int unsigned DEBUG_WIDTH = 3;

  // Widest target address; only this many low command-address bits are ever used.
  localparam int unsigned ADDR_KEEP_WIDTH =
      (IADDR_WIDTH >= DADDR_WIDTH) ?
      ((IADDR_WIDTH >= RADDR_WIDTH) ? IADDR_WIDTH : RADDR_WIDTH) :
      ((DADDR_WIDTH >= RADDR_WIDTH) ? DADDR_WIDTH : RADDR_WIDTH);

  // Modes understood by cpu_state_mux.
  localparam logic [DEBUG_WIDTH-1:0] DEBUG_NONE  = 3'd0;
  localparam logic [DEBUG_WIDTH-1:0] DEBUG_ICRD  = 3'd1;
  localparam logic [DEBUG_WIDTH-1:0] DEBUG_ICWR  = 3'd2;
  localparam logic [DEBUG_WIDTH-1:0] DEBUG_REGRD = 3'd3;
  localparam logic [DEBUG_WIDTH-1:0] DEBUG_DCRD  = 3'd4;

  // Command opcodes; 5..7 are illegal.
  localparam logic [2:0] DBG_OP_ICRD   = 3'd0;
  localparam logic [2:0] DBG_OP_ICWR   = 3'd1;
  localparam logic [2:0] DBG_OP_REGRD  = 3'd2;
  localparam logic [2:0] DBG_OP_DCRD   = 3'd3;
  localparam logic [2:0] DBG_OP_RESUME = 3'd4;

  function automatic logic [DEBUG_WIDTH-1:0] op_to_mode(input logic [2:0] op);
    logic [DEBUG_WIDTH-1:0] mode;
    case (op)
      DBG_OP_ICRD:  mode = DEBUG_ICRD;
      DBG_OP_ICWR:  mode = DEBUG_ICWR;
      DBG_OP_REGRD: mode = DEBUG_REGRD;
      DBG_OP_DCRD:  mode = DEBUG_DCRD;
      default:      mode = DEBUG_NONE;
    endcase
    return mode;
  endfunction

  function automatic logic is_access_op(input logic [2:0] op);
    return (op == DBG_OP_ICRD) || (op == DBG_OP_ICWR) ||
           (op == DBG_OP_REGRD) || (op == DBG_OP_DCRD);
  endfunction

endpackage

// File: rtl/debug_access_ctrl.sv
// Sequences one external debug access at a time into icache, regfile port 2 or dcache,
// halting the core first and returning captured read data over a valid/ready response.
module debug_access_ctrl
  import debug_access_ctrl_pkg::*;
#(
  parameter int unsigned HALT_TIMEOUT = 255
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic [2:0]             cmd_op,
  input  logic [31:0]            cmd_addr,
  input  logic [DATA_WIDTH-1:0]  cmd_wdata,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [DATA_WIDTH-1:0]  rsp_data,
  output logic                   rsp_err,
  output logic                   cpu_halt_req,
  input  logic                   cpu_halted,
  output logic [DEBUG_WIDTH-1:0] debug,
  output logic                   ext_icache_ceb,
  output logic                   ext_icache_web,
  output logic [IADDR_WIDTH-1:0] ext_icache_addr,
  output logic [DATA_WIDTH-1:0]  ext_icache_wdata,
  input  logic [DATA_WIDTH-1:0]  icache_rdata,
  output logic                   ext_reg_read2,
  output logic [RADDR_WIDTH-1:0] ext_reg_rs2,
  input  logic [DATA_WIDTH-1:0]  reg_rdata2,
  output logic                   ext_dcache_ceb,
  output logic                   ext_dcache_web,
  output logic [DATA_WIDTH-1:0]  ext_dcache_bweb,
  output logic [DADDR_WIDTH-1:0] ext_dcache_addr,
  input  logic [DATA_WIDTH-1:0]  dcache_rdata
);

  typedef enum logic [2:0] {
    StIdle,
    StHalt,
    StSetup,
    StAccess,
    StCapture,
    StResp
  } state_e;

  localparam logic [15:0] TimeoutCnt = 16'(HALT_TIMEOUT);

  state_e                     state_q, state_d;
  logic [2:0]                 op_q, op_d;
  logic [ADDR_KEEP_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0]      wdata_q, wdata_d;
  logic [15:0]                wait_cnt_q, wait_cnt_d;
  logic [15:0]                wait_cnt_inc;

  logic                   cmd_ready_q, cmd_ready_d;
  logic                   rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0]  rsp_data_q, rsp_data_d;
  logic                   rsp_err_q, rsp_err_d;
  logic                   halt_req_q, halt_req_d;
  logic [DEBUG_WIDTH-1:0] debug_q, debug_d;
  logic                   ic_ceb_q, ic_ceb_d;
  logic                   ic_web_q, ic_web_d;
  logic [IADDR_WIDTH-1:0] ic_addr_q, ic_addr_d;
  logic [DATA_WIDTH-1:0]  ic_wdata_q, ic_wdata_d;
  logic                   read2_q, read2_d;
  logic [RADDR_WIDTH-1:0] rs2_q, rs2_d;
  logic                   dc_ceb_q, dc_ceb_d;
  logic [DADDR_WIDTH-1:0] dc_addr_q, dc_addr_d;

  // Upper command-address bits are deliberately ignored.
  logic unused_cmd_addr;
  assign unused_cmd_addr = ^cmd_addr[31:ADDR_KEEP_WIDTH];

  assign wait_cnt_inc = (wait_cnt_q == 16'hFFFF) ? wait_cnt_q : wait_cnt_q + 16'd1;

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    wait_cnt_d  = wait_cnt_q;
    cmd_ready_d = cmd_ready_q;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    rsp_err_d   = rsp_err_q;
    halt_req_d  = halt_req_q;
    debug_d     = debug_q;
    ic_ceb_d    = ic_ceb_q;
    ic_web_d    = ic_web_q;
    ic_addr_d   = ic_addr_q;
    ic_wdata_d  = ic_wdata_q;
    read2_d     = read2_q;
    rs2_d       = rs2_q;
    dc_ceb_d    = dc_ceb_q;
    dc_addr_d   = dc_addr_q;

    unique case (state_q)
      StIdle: begin
        if (cmd_valid) begin
          cmd_ready_d = 1'b0;
          op_d        = cmd_op;
          addr_d      = cmd_addr[ADDR_KEEP_WIDTH-1:0];
          wdata_d     = cmd_wdata;
          wait_cnt_d  = '0;
          rsp_data_d  = '0;
          rsp_err_d   = 1'b0;
          if (is_access_op(cmd_op)) begin
            halt_req_d = 1'b1;
            state_d    = StHalt;
          end else if (cmd_op == DBG_OP_RESUME) begin
            halt_req_d  = 1'b0;
            rsp_valid_d = 1'b1;
            state_d     = StResp;
          end else begin
            rsp_err_d   = 1'b1;
            rsp_valid_d = 1'b1;
            state_d     = StResp;
          end
        end
      end

      StHalt: begin
        if (cpu_halted) begin
          state_d = StSetup;
          debug_d = op_to_mode(op_q);
          case (op_q)
            DBG_OP_ICRD: ic_addr_d = addr_q[IADDR_WIDTH-1:0];
            DBG_OP_ICWR: begin
              ic_addr_d  = addr_q[IADDR_WIDTH-1:0];
              ic_wdata_d = wdata_q;
            end
            DBG_OP_REGRD: rs2_d     = addr_q[RADDR_WIDTH-1:0];
            default:      dc_addr_d = addr_q[DADDR_WIDTH-1:0];
          endcase
        end else begin
          wait_cnt_d = wait_cnt_inc;
          // Give up without touching any SRAM; halt request stays asserted.
          if (wait_cnt_inc >= TimeoutCnt) begin
            rsp_err_d   = 1'b1;
            rsp_data_d  = '0;
            rsp_valid_d = 1'b1;
            state_d     = StResp;
          end
        end
      end

      StSetup: begin
        state_d = StAccess;
        case (op_q)
          DBG_OP_ICRD: ic_ceb_d = 1'b0;
          DBG_OP_ICWR: begin
            ic_ceb_d = 1'b0;
            ic_web_d = 1'b0;
          end
          DBG_OP_REGRD: read2_d  = 1'b1;
          default:      dc_ceb_d = 1'b0;
        endcase
      end

      StAccess: begin
        state_d  = StCapture;
        ic_ceb_d = 1'b1;
        ic_web_d = 1'b1;
        read2_d  = 1'b0;
        dc_ceb_d = 1'b1;
      end

      StCapture: begin
        state_d     = StResp;
        debug_d     = DEBUG_NONE;
        rsp_valid_d = 1'b1;
        rsp_err_d   = 1'b0;
        case (op_q)
          DBG_OP_ICRD:  rsp_data_d = icache_rdata;
          DBG_OP_REGRD: rsp_data_d = reg_rdata2;
          DBG_OP_DCRD:  rsp_data_d = dcache_rdata;
          default:      rsp_data_d = '0;
        endcase
      end

      StResp: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          cmd_ready_d = 1'b1;
          state_d     = StIdle;
        end
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      op_q        <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      wait_cnt_q  <= '0;
      cmd_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
      halt_req_q  <= 1'b0;
      debug_q     <= DEBUG_NONE;
      ic_ceb_q    <= 1'b1;
      ic_web_q    <= 1'b1;
      ic_addr_q   <= '0;
      ic_wdata_q  <= '0;
      read2_q     <= 1'b0;
      rs2_q       <= '0;
      dc_ceb_q    <= 1'b1;
      dc_addr_q   <= '0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      wait_cnt_q  <= wait_cnt_d;
      cmd_ready_q <= cmd_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_err_q   <= rsp_err_d;
      halt_req_q  <= halt_req_d;
      debug_q     <= debug_d;
      ic_ceb_q    <= ic_ceb_d;
      ic_web_q    <= ic_web_d;
      ic_addr_q   <= ic_addr_d;
      ic_wdata_q  <= ic_wdata_d;
      read2_q     <= read2_d;
      rs2_q       <= rs2_d;
      dc_ceb_q    <= dc_ceb_d;
      dc_addr_q   <= dc_addr_d;
    end
  end

  assign cmd_ready        = cmd_ready_q;
  assign rsp_valid        = rsp_valid_q;
  assign rsp_data         = rsp_data_q;
  assign rsp_err          = rsp_err_q;
  assign cpu_halt_req     = halt_req_q;
  assign debug            = debug_q;
  assign ext_icache_ceb   = ic_ceb_q;
  assign ext_icache_web   = ic_web_q;
  assign ext_icache_addr  = ic_addr_q;
  assign ext_icache_wdata = ic_wdata_q;
  assign ext_reg_read2    = read2_q;
  assign ext_reg_rs2      = rs2_q;
  assign ext_dcache_ceb   = dc_ceb_q;
  assign ext_dcache_addr  = dc_addr_q;
  // The debug path never writes the dcache.
  assign ext_dcache_web   = 1'b1;
  assign ext_dcache_bweb  = '1;

endmodule

// File: tb/tb_debug_access_ctrl.sv
// Directed bench for debug_access_ctrl: vector table of commands with hand-computed responses,
// SRAM/regfile models, plus a reset-during-access sequence.
module tb_debug_access_ctrl;
  import debug_access_ctrl_pkg::*;

  logic                   clk = 1'b0;
  logic                   rst_n;
  logic                   cmd_valid;
  logic                   cmd_ready;
  logic [2:0]             cmd_op;
  logic [31:0]            cmd_addr;
  logic [DATA_WIDTH-1:0]  cmd_wdata;
  logic                   rsp_valid;
  logic                   rsp_ready;
  logic [DATA_WIDTH-1:0]  rsp_data;
  logic                   rsp_err;
  logic                   cpu_halt_req;
  logic                   cpu_halted;
  logic [DEBUG_WIDTH-1:0] debug;
  logic                   ext_icache_ceb, ext_icache_web;
  logic [IADDR_WIDTH-1:0] ext_icache_addr;
  logic [DATA_WIDTH-1:0]  ext_icache_wdata;
  logic [DATA_WIDTH-1:0]  icache_rdata;
  logic                   ext_reg_read2;
  logic [RADDR_WIDTH-1:0] ext_reg_rs2;
  logic [DATA_WIDTH-1:0]  reg_rdata2;
  logic                   ext_dcache_ceb, ext_dcache_web;
  logic [DATA_WIDTH-1:0]  ext_dcache_bweb;
  logic [DADDR_WIDTH-1:0] ext_dcache_addr;
  logic [DATA_WIDTH-1:0]  dcache_rdata;

  always #5 clk = ~clk;

  debug_access_ctrl #(.HALT_TIMEOUT(8)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .cmd_valid        (cmd_valid),
    .cmd_ready        (cmd_ready),
    .cmd_op           (cmd_op),
    .cmd_addr         (cmd_addr),
    .cmd_wdata        (cmd_wdata),
    .rsp_valid        (rsp_valid),
    .rsp_ready        (rsp_ready),
    .rsp_data         (rsp_data),
    .rsp_err          (rsp_err),
    .cpu_halt_req     (cpu_halt_req),
    .cpu_halted       (cpu_halted),
    .debug            (debug),
    .ext_icache_ceb   (ext_icache_ceb),
    .ext_icache_web   (ext_icache_web),
    .ext_icache_addr  (ext_icache_addr),
    .ext_icache_wdata (ext_icache_wdata),
    .icache_rdata     (icache_rdata),
    .ext_reg_read2    (ext_reg_read2),
    .ext_reg_rs2      (ext_reg_rs2),
    .reg_rdata2       (reg_rdata2),
    .ext_dcache_ceb   (ext_dcache_ceb),
    .ext_dcache_web   (ext_dcache_web),
    .ext_dcache_bweb  (ext_dcache_bweb),
    .ext_dcache_addr  (ext_dcache_addr),
    .dcache_rdata     (dcache_rdata)
  );

  // Memory models: data appears the cycle after the strobe.
  logic [DATA_WIDTH-1:0] ic_mem [1024];
  logic [DATA_WIDTH-1:0] dc_mem [1024];
  logic [DATA_WIDTH-1:0] rf     [32];

  always @(posedge clk) begin
    if (!ext_icache_ceb) begin
      if (!ext_icache_web) ic_mem[ext_icache_addr] <= ext_icache_wdata;
      else icache_rdata <= ic_mem[ext_icache_addr];
    end
    if (!ext_dcache_ceb) dcache_rdata <= dc_mem[ext_dcache_addr];
    if (ext_reg_read2) reg_rdata2 <= rf[ext_reg_rs2];
  end

  typedef struct {
    logic [2:0]             op;
    logic [31:0]            addr;
    logic [31:0]            wdata;
    int                     halt_wait;
    int                     ready_hold;
    int                     exp_lat;
    logic [31:0]            exp_data;
    logic                   exp_err;
    logic                   exp_halt;
    logic [3:0]             exp_strb;  // {icache ceb, icache web, read2, dcache ceb} pulses
    logic [DEBUG_WIDTH-1:0] exp_dbg;
  } vec_t;

  vec_t vecs[$];
  int   tests = 0;
  int   fails = 0;

  function automatic vec_t mk(input logic [2:0] op, input logic [31:0] addr,
                              input logic [31:0] wdata, input int hw, input int rh,
                              input int lat, input logic [31:0] d, input logic err,
                              input logic halt, input logic [3:0] strb,
                              input logic [DEBUG_WIDTH-1:0] dbg);
    vec_t v;
    v.op = op; v.addr = addr; v.wdata = wdata; v.halt_wait = hw; v.ready_hold = rh;
    v.exp_lat = lat; v.exp_data = d; v.exp_err = err; v.exp_halt = halt;
    v.exp_strb = strb; v.exp_dbg = dbg;
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_reset_values(input string p);
    check({p, "_ctrl"},
          {52'd0, cmd_ready, rsp_valid, rsp_err, cpu_halt_req, debug, ext_icache_ceb,
           ext_icache_web, ext_reg_read2, ext_dcache_ceb, ext_dcache_web},
          {52'd0, 1'b1, 1'b0, 1'b0, 1'b0, DEBUG_NONE, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1});
    check({p, "_addrs"}, {39'd0, ext_icache_addr, ext_reg_rs2, ext_dcache_addr}, 64'd0);
    check({p, "_wdata"}, {32'd0, ext_icache_wdata}, 64'd0);
    check({p, "_rsp_data"}, {32'd0, rsp_data}, 64'd0);
    check({p, "_bweb"}, {32'd0, ext_dcache_bweb}, {32'd0, 32'hFFFF_FFFF});
  endtask

  // Starts at a negedge with the DUT idle; returns at a negedge with the DUT idle again.
  task automatic run_vec(input int idx, input vec_t v);
    int lat = 0;
    bit got = 0;
    int c_icceb = 0, c_icweb = 0, c_rd2 = 0, c_dcceb = 0, const_bad = 0;
    logic [DEBUG_WIDTH-1:0] acc_dbg = DEBUG_NONE;
    string p = $sformatf("v%0d", idx);
    check({p, "_cmd_ready"}, {63'd0, cmd_ready}, 64'd1);
    cmd_valid  = 1'b1;
    cmd_op     = v.op;
    cmd_addr   = v.addr;
    cmd_wdata  = v.wdata;
    cpu_halted = (v.halt_wait == 0);
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    cmd_op    = 3'd0;
    cmd_addr  = '0;
    cmd_wdata = '0;
    while (!got && lat < 40) begin
      lat++;
      @(negedge clk);
      cpu_halted = (lat > v.halt_wait);
      if (!ext_icache_ceb) c_icceb++;
      if (!ext_icache_web) c_icweb++;
      if (ext_reg_read2) c_rd2++;
      if (!ext_dcache_ceb) c_dcceb++;
      if (!ext_icache_ceb || ext_reg_read2 || !ext_dcache_ceb) acc_dbg = debug;
      if (ext_dcache_web !== 1'b1 || ext_dcache_bweb !== '1) const_bad++;
      if (rsp_valid) got = 1;
    end
    check({p, "_latency"}, 64'(lat), 64'(v.exp_lat));
    check({p, "_rsp_data"}, {32'd0, rsp_data}, {32'd0, v.exp_data});
    check({p, "_rsp_err"}, {63'd0, rsp_err}, {63'd0, v.exp_err});
    check({p, "_halt_req"}, {63'd0, cpu_halt_req}, {63'd0, v.exp_halt});
    check({p, "_strobes"}, {48'd0, 4'(c_icceb), 4'(c_icweb), 4'(c_rd2), 4'(c_dcceb)},
          {48'd0, 3'd0, v.exp_strb[3], 3'd0, v.exp_strb[2], 3'd0, v.exp_strb[1],
           3'd0, v.exp_strb[0]});
    check({p, "_access_debug"}, 64'(acc_dbg), 64'(v.exp_dbg));
    check({p, "_resp_debug"}, 64'(debug), 64'(DEBUG_NONE));
    check({p, "_dcache_const"}, 64'(const_bad), 64'd0);
    for (int k = 0; k < v.ready_hold; k++) begin
      @(negedge clk);
      check($sformatf("%s_hold%0d", p, k), {31'd0, rsp_valid, rsp_data},
            {31'd0, 1'b1, v.exp_data});
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    check({p, "_handshake"}, {62'd0, rsp_valid, cmd_ready}, 64'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n      = 1'b1;
    cmd_valid  = 1'b0;
    cmd_op     = 3'd0;
    cmd_addr   = '0;
    cmd_wdata  = '0;
    rsp_ready  = 1'b0;
    cpu_halted = 1'b0;
    for (int i = 0; i < 32; i++) rf[i] = 32'(i);
    rf[5]  = 32'h0000_1234;
    rf[31] = 32'h8000_0001;
    for (int i = 0; i < 1024; i++) dc_mem[i] = 32'(i) ^ 32'h5A5A_0000;
    dc_mem[32'h20] = 32'hCAFE_F00D;
    dc_mem[32'h21] = 32'h0BAD_F00D;

    //           op            addr        wdata         hw    rh lat data          e  h  strb     dbg
    vecs.push_back(mk(DBG_OP_ICWR,   32'h10,  32'hDEADBEEF, 0,    0, 5, 32'h0,        0, 1, 4'b1100, DEBUG_ICWR));
    vecs.push_back(mk(DBG_OP_ICRD,   32'h10,  32'h0,        0,    0, 5, 32'hDEADBEEF, 0, 1, 4'b1000, DEBUG_ICRD));
    vecs.push_back(mk(DBG_OP_REGRD,  32'h5,   32'h0,        0,    4, 5, 32'h1234,     0, 1, 4'b0010, DEBUG_REGRD));
    vecs.push_back(mk(DBG_OP_ICWR,   32'h3FF, 32'hA5A50F0F, 0,    0, 5, 32'h0,        0, 1, 4'b1100, DEBUG_ICWR));
    vecs.push_back(mk(DBG_OP_ICRD,   32'h3FF, 32'h0,        0,    0, 5, 32'hA5A50F0F, 0, 1, 4'b1000, DEBUG_ICRD));
    vecs.push_back(mk(DBG_OP_ICRD,   32'h410, 32'h0,        0,    0, 5, 32'hDEADBEEF, 0, 1, 4'b1000, DEBUG_ICRD));
    vecs.push_back(mk(DBG_OP_REGRD,  32'h1F,  32'h0,        0,    0, 5, 32'h80000001, 0, 1, 4'b0010, DEBUG_REGRD));
    vecs.push_back(mk(DBG_OP_DCRD,   32'h20,  32'h0,        0,    0, 5, 32'hCAFEF00D, 0, 1, 4'b0001, DEBUG_DCRD));
    vecs.push_back(mk(3'd6,          32'h10,  32'h0,        0,    0, 1, 32'h0,        1, 1, 4'b0000, DEBUG_NONE));
    vecs.push_back(mk(DBG_OP_RESUME, 32'h0,   32'h0,        0,    0, 1, 32'h0,        0, 0, 4'b0000, DEBUG_NONE));
    vecs.push_back(mk(3'd5,          32'h0,   32'h0,        0,    0, 1, 32'h0,        1, 0, 4'b0000, DEBUG_NONE));
    vecs.push_back(mk(DBG_OP_DCRD,   32'h21,  32'h0,        3,    0, 8, 32'h0BADF00D, 0, 1, 4'b0001, DEBUG_DCRD));
    vecs.push_back(mk(DBG_OP_RESUME, 32'h0,   32'h0,        0,    0, 1, 32'h0,        0, 0, 4'b0000, DEBUG_NONE));
    vecs.push_back(mk(DBG_OP_ICRD,   32'h10,  32'h0,        1000, 0, 9, 32'h0,        1, 1, 4'b0000, DEBUG_NONE));
    vecs.push_back(mk(3'd7,          32'h0,   32'h0,        0,    0, 1, 32'h0,        1, 1, 4'b0000, DEBUG_NONE));

    #2 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_values("reset");
    rst_n = 1'b1;
    @(negedge clk);

    foreach (vecs[i]) run_vec(i, vecs[i]);

    // Asynchronous reset in the middle of an icache write access.
    cmd_valid  = 1'b1;
    cmd_op     = DBG_OP_ICWR;
    cmd_addr   = 32'h55;
    cmd_wdata  = 32'h1111_2222;
    cpu_halted = 1'b1;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("mid_access_strobe", {59'd0, ext_icache_ceb, ext_icache_web, debug},
          {59'd0, 1'b0, 1'b0, DEBUG_ICWR});
    #2 rst_n = 1'b0;
    #1;
    check_reset_values("async_reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    run_vec(99, mk(DBG_OP_ICRD, 32'h10, 32'h0, 0, 0, 5, 32'hDEADBEEF, 0, 1, 4'b1000,
                   DEBUG_ICRD));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
